// File: rtl/cnn_weight_pkg.sv
// Shared constants, FSM state type and word-slice helper for the weight row streamer.
package cnn_weight_pkg;

   localparam int unsigned W_DATA      = 32;
   localparam int unsigned W_ROW_WORDS = 32;
   localparam int unsigned W_ADDR      = 7;
   localparam int unsigned ROWS        = 128;
   localparam int unsigned W_ROW       = W_DATA * W_ROW_WORDS;
   localparam int unsigned W_IDX       = $clog2(W_ROW_WORDS);

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      CAPTURE,
      STREAM,
      DONE
   } state_t;

   // Word k of a row; word 0 sits in the least significant bits.
   function automatic logic [W_DATA-1:0] word_slice(input logic [W_ROW-1:0] row,
                                                    input logic [W_IDX-1:0] k);
      return row[W_DATA*k +: W_DATA];
   endfunction

endpackage

// File: rtl/weight_row_streamer_if.sv
// Word stream from the weight row streamer into the MAC datapath.
interface weight_row_streamer_if
   import cnn_weight_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = W_DATA
);

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [W_IDX-1:0]      out_word_idx;
   logic                  out_last_word;
   logic                  out_last_row;

   modport master (
      output out_valid,
      output out_data,
      output out_word_idx,
      output out_last_word,
      output out_last_row,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_word_idx,
      input  out_last_word,
      input  out_last_row,
      output out_ready
   );

endinterface

// File: rtl/row_serializer.sv
// Holds one captured memory row and hands it out word by word over valid/ready.
module row_serializer
   import cnn_weight_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = W_DATA,
   parameter int unsigned WORDS_PER_ROW = W_ROW_WORDS
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                load,
   input  logic                                final_row,
   input  logic [DATA_WIDTH*WORDS_PER_ROW-1:0] row,
   output logic                                row_done,
   weight_row_streamer_if.master               stream
);

   localparam logic [W_IDX-1:0] LastIdx = W_IDX'(WORDS_PER_ROW - 1);
   localparam logic [W_IDX-1:0] IdxOne  = W_IDX'(1);

   logic [DATA_WIDTH*WORDS_PER_ROW-1:0] row_q;
   logic [W_IDX-1:0]                    idx_q;
   logic                                valid_q;
   logic                                last_row_q;
   logic                                xfer;

   assign xfer     = valid_q && stream.out_ready;
   assign row_done = xfer && (idx_q == LastIdx);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         row_q      <= '0;
         idx_q      <= '0;
         valid_q    <= 1'b0;
         last_row_q <= 1'b0;
      end else if (load) begin
         row_q      <= row;
         idx_q      <= '0;
         valid_q    <= 1'b1;
         last_row_q <= final_row;
      end else if (xfer) begin
         // Index wraps back to 0 after the last word, ready for the next load.
         idx_q <= idx_q + IdxOne;
         if (idx_q == LastIdx) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign stream.out_valid     = valid_q;
   assign stream.out_data      = word_slice(row_q, idx_q);
   assign stream.out_word_idx  = idx_q;
   assign stream.out_last_word = valid_q && (idx_q == LastIdx);
   assign stream.out_last_row  = valid_q && last_row_q;

endmodule

// File: rtl/weight_row_streamer.sv
// Job FSM: fetches a run of weight rows from memory and streams each row out word by word.
module weight_row_streamer
   import cnn_weight_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = W_DATA,
   parameter int unsigned WORDS_PER_ROW = W_ROW_WORDS,
   parameter int unsigned ADDR_WIDTH    = W_ADDR,
   parameter int unsigned MEM_LATENCY   = 1
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                start,
   input  logic [ADDR_WIDTH-1:0]               base_row,
   input  logic [ADDR_WIDTH:0]                 row_count,
   output logic                                busy,
   output logic                                done,
   output logic [ADDR_WIDTH-1:0]               address,
   input  logic [DATA_WIDTH*WORDS_PER_ROW-1:0] weights,
   weight_row_streamer_if.master               stream
);

   localparam logic [1:0]            LatLast = 2'(MEM_LATENCY - 1);
   localparam logic [ADDR_WIDTH:0]   OneRow  = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
   // With a combinational memory the latency wait is skipped entirely.
   localparam state_t FetchState = (MEM_LATENCY == 0) ? CAPTURE : WAIT;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] address_q, address_d;
   logic [ADDR_WIDTH:0]   rows_left_q, rows_left_d;
   logic [1:0]            lat_cnt_q, lat_cnt_d;
   logic                  done_q, done_d;
   logic                  load;
   logic                  final_row;
   logic                  row_done;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         address_q   <= '0;
         rows_left_q <= '0;
         lat_cnt_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         address_q   <= address_d;
         rows_left_q <= rows_left_d;
         lat_cnt_q   <= lat_cnt_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      address_d   = address_q;
      rows_left_d = rows_left_q;
      lat_cnt_d   = lat_cnt_q;
      done_d      = 1'b0;
      load        = 1'b0;
      final_row   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (row_count != '0) begin
                  rows_left_d = row_count;
                  address_d   = base_row;
                  lat_cnt_d   = '0;
                  state_d     = FetchState;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         WAIT: begin
            if (lat_cnt_q == LatLast) begin
               state_d = CAPTURE;
            end else begin
               lat_cnt_d = lat_cnt_q + 2'd1;
            end
         end
         CAPTURE: begin
            load        = 1'b1;
            rows_left_d = rows_left_q - OneRow;
            final_row   = (rows_left_q == OneRow);
            // Memory starts on the next row while this one streams out.
            address_d   = address_q + AddrOne;
            state_d     = STREAM;
         end
         STREAM: begin
            if (row_done) begin
               if (rows_left_q != '0) begin
                  lat_cnt_d = '0;
                  state_d   = FetchState;
               end else begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   row_serializer #(
      .DATA_WIDTH   (DATA_WIDTH),
      .WORDS_PER_ROW(WORDS_PER_ROW)
   ) u_row_serializer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load),
      .final_row(final_row),
      .row      (weights),
      .row_done (row_done),
      .stream   (stream)
   );

   assign busy    = (state_q == WAIT) || (state_q == CAPTURE) || (state_q == STREAM);
   assign done    = done_q;
   assign address = address_q;

endmodule
